// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin arbiter giving two requesters access to one 32-bit data RAM,
// with RV32I store lane steering and load byte/half extraction and extension.
module dmem_arbiter #(
    parameter int RAM_AW  = 10,
    parameter int BYTE_AW = RAM_AW + 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic               i_a_req,
    input  logic               i_a_we,
    input  logic [BYTE_AW-1:0] i_a_addr,
    input  logic [31:0]        i_a_wdata,
    input  logic [2:0]         i_a_funct3,
    input  logic               i_b_req,
    input  logic               i_b_we,
    input  logic [BYTE_AW-1:0] i_b_addr,
    input  logic [31:0]        i_b_wdata,
    input  logic [2:0]         i_b_funct3,
    output logic               o_a_gnt,
    output logic               o_b_gnt,
    output logic               o_a_rvalid,
    output logic               o_b_rvalid,
    output logic [31:0]        o_a_rdata,
    output logic [31:0]        o_b_rdata,
    output logic               o_a_err,
    output logic               o_b_err,
    output logic               o_ram_en,
    output logic [3:0]         o_ram_we,
    output logic [RAM_AW-1:0]  o_ram_addr,
    output logic [31:0]        o_ram_wdata,
    input  logic [31:0]        i_ram_rdata,
    output logic               o_busy
);

    localparam logic [2:0] S_NONE  = 3'd0;
    localparam logic [2:0] S_RD_A  = 3'd1;
    localparam logic [2:0] S_RD_B  = 3'd2;
    localparam logic [2:0] S_ERR_A = 3'd3;
    localparam logic [2:0] S_ERR_B = 3'd4;

    logic [2:0] state_q, state_d;
    logic       rr_q, rr_d;        // 1: B wins the next conflict
    logic [1:0] off_q, off_d;
    logic [2:0] f3_q, f3_d;

    logic               gnt_any;
    logic               sel_we;
    logic [BYTE_AW-1:0] sel_addr;
    logic [31:0]        sel_wdata;
    logic [2:0]         sel_f3;
    logic               sel_legal;
    logic [31:0]        rd_shift;
    logic [31:0]        rd_ext;

    function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  is_legal = 1'b1;
            3'b001:  is_legal = ~a[0];
            3'b010:  is_legal = (a == 2'b00);
            3'b100:  is_legal = ~we;
            3'b101:  is_legal = ~we & ~a[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

    // Grants are gated by reset so every output drops the moment reset asserts.
    assign o_a_gnt = i_clk_en & i_rst_n & i_a_req & ~(i_b_req & rr_q);
    assign o_b_gnt = i_clk_en & i_rst_n & i_b_req & ~(i_a_req & ~rr_q);
    assign gnt_any = o_a_gnt | o_b_gnt;

    assign sel_we    = o_b_gnt ? i_b_we     : i_a_we;
    assign sel_addr  = o_b_gnt ? i_b_addr   : i_a_addr;
    assign sel_wdata = o_b_gnt ? i_b_wdata  : i_a_wdata;
    assign sel_f3    = o_b_gnt ? i_b_funct3 : i_a_funct3;
    assign sel_legal = is_legal(sel_we, sel_f3, sel_addr[1:0]);

    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 4'b0000;
        o_ram_addr  = '0;
        o_ram_wdata = 32'h0;
        if (gnt_any && sel_legal) begin
            o_ram_en   = 1'b1;
            o_ram_addr = sel_addr[BYTE_AW-1:2];
            if (sel_we) begin
                case (sel_f3[1:0])
                    2'b00: begin
                        o_ram_we    = 4'b0001 << sel_addr[1:0];
                        o_ram_wdata = {4{sel_wdata[7:0]}};
                    end
                    2'b01: begin
                        o_ram_we    = 4'b0011 << sel_addr[1:0];
                        o_ram_wdata = {2{sel_wdata[15:0]}};
                    end
                    default: begin
                        o_ram_we    = 4'b1111;
                        o_ram_wdata = sel_wdata;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d = S_NONE;
        rr_d    = rr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        if (gnt_any) begin
            rr_d = o_a_gnt;
            if (!sel_legal) begin
                state_d = o_b_gnt ? S_ERR_B : S_ERR_A;
            end else if (!sel_we) begin
                state_d = o_b_gnt ? S_RD_B : S_RD_A;
                off_d   = sel_addr[1:0];
                f3_d    = sel_f3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_NONE;
            rr_q    <= 1'b0;
            off_q   <= 2'b00;
            f3_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
        end
    end

    assign rd_shift = i_ram_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = i_ram_rdata;
        endcase
    end

    assign o_a_rvalid = (state_q == S_RD_A);
    assign o_b_rvalid = (state_q == S_RD_B);
    assign o_a_rdata  = o_a_rvalid ? rd_ext : 32'h0;
    assign o_b_rdata  = o_b_rvalid ? rd_ext : 32'h0;
    assign o_a_err    = (state_q == S_ERR_A);
    assign o_b_err    = (state_q == S_ERR_B);
    assign o_busy     = i_rst_n & (i_a_req | i_b_req | (state_q != S_NONE));

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed and random stimulus against a byte-level memory reference model.
module tb_dmem_arbiter;

    localparam int RAM_AW  = 10;
    localparam int BYTE_AW = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_en;
    logic               a_req, a_we, b_req, b_we;
    logic [BYTE_AW-1:0] a_addr, b_addr;
    logic [31:0]        a_wdata, b_wdata;
    logic [2:0]         a_f3, b_f3;
    logic               a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
    logic [31:0]        a_rdata, b_rdata;
    logic               ram_en;
    logic [3:0]         ram_we;
    logic [RAM_AW-1:0]  ram_addr;
    logic [31:0]        ram_wdata;
    logic [31:0]        ram_rdata;
    logic               busy;

    dmem_arbiter #(.RAM_AW(RAM_AW), .BYTE_AW(BYTE_AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_funct3(a_f3),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_funct3(b_f3),
        .o_a_gnt(a_gnt), .o_b_gnt(b_gnt), .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
        .o_a_rdata(a_rdata), .o_b_rdata(b_rdata), .o_a_err(a_err), .o_b_err(b_err),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] ram     [0:(1<<RAM_AW)-1];
    logic [7:0]  ref_mem [0:(1<<BYTE_AW)-1];

    int errors = 0;
    int checks = 0;

    // Reference model state: who wins a conflict, and what response is owed next cycle.
    logic        fav_b;
    int          pend_kind;   // 0 none, 1 load data, 2 error
    logic        pend_b;
    logic [31:0] pend_val;
    logic        m_ga, m_gb;

    logic        obs_ga, obs_gb, obs_ram_en, obs_a_rvalid, obs_b_rvalid, obs_a_err, obs_busy;
    logic [3:0]  obs_ram_we;
    logic [RAM_AW-1:0] obs_ram_addr;
    logic [31:0] obs_ram_wdata, obs_a_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        int sz;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        if (we && f3[2]) return 1'b0;
        sz = 1 << f3[1:0];
        return (int'(off) % sz) == 0;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] val);
        ram[idx] = val;
        for (int k = 0; k < 4; k++) ref_mem[idx*4+k] = val[8*k +: 8];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'h0, a_gnt, b_gnt}, 32'h0);
        chk({tag, "_resp"}, {28'h0, a_rvalid, b_rvalid, a_err, b_err}, 32'h0);
        chk({tag, "_rdata"}, a_rdata | b_rdata, 32'h0);
        chk({tag, "_ram"}, {26'h0, ram_en, ram_we, busy}, 32'h0);
        chk({tag, "_ramaw"}, ram_addr | ram_wdata, 32'h0);
    endtask

    // One clock cycle: entered and left at posedge+1 with inputs already applied.
    task automatic do_cycle();
        logic ega, egb, lg, we;
        logic [BYTE_AW-1:0] ad;
        logic [2:0] f;
        logic [31:0] wd, ewd, v;
        logic [3:0] ewe;
        int sz, off;
        logic cap_en;
        logic [3:0] cap_we;
        logic [RAM_AW-1:0] cap_addr;
        logic [31:0] cap_wd;

        ega = clk_en && a_req && !(b_req && fav_b);
        egb = clk_en && b_req && !(a_req && !fav_b);
        we  = egb ? b_we : a_we;
        ad  = egb ? b_addr : a_addr;
        f   = egb ? b_f3 : a_f3;
        wd  = egb ? b_wdata : a_wdata;
        lg  = ref_legal(we, f, ad[1:0]);
        sz  = 1 << f[1:0];
        off = int'(ad[1:0]);
        ewe = 4'h0;
        ewd = 32'h0;
        if ((ega || egb) && lg && we) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= off && k < off + sz) ewe[k] = 1'b1;
                ewd[8*k +: 8] = wd[8*(k % sz) +: 8];
            end
        end

        @(negedge clk);
        chk("gnt_a", a_gnt, ega);
        chk("gnt_b", b_gnt, egb);
        chk("ram_en", ram_en, (ega || egb) && lg);
        chk("ram_addr", ram_addr, ((ega || egb) && lg) ? 32'(ad >> 2) : 32'h0);
        chk("ram_we", ram_we, ewe);
        chk("ram_wdata", ram_wdata, ewd);
        chk("rvalid_a", a_rvalid, pend_kind == 1 && !pend_b);
        chk("rvalid_b", b_rvalid, pend_kind == 1 && pend_b);
        chk("rdata_a", a_rdata, (pend_kind == 1 && !pend_b) ? pend_val : 32'h0);
        chk("rdata_b", b_rdata, (pend_kind == 1 && pend_b) ? pend_val : 32'h0);
        chk("err_a", a_err, pend_kind == 2 && !pend_b);
        chk("err_b", b_err, pend_kind == 2 && pend_b);
        chk("busy", busy, a_req || b_req || pend_kind != 0);

        obs_ga = a_gnt; obs_gb = b_gnt; obs_ram_en = ram_en; obs_ram_we = ram_we;
        obs_ram_addr = ram_addr; obs_ram_wdata = ram_wdata; obs_a_rvalid = a_rvalid;
        obs_b_rvalid = b_rvalid; obs_a_rdata = a_rdata; obs_a_err = a_err; obs_busy = busy;
        cap_en = ram_en; cap_we = ram_we; cap_addr = ram_addr; cap_wd = ram_wdata;

        m_ga = ega;
        m_gb = egb;
        pend_kind = 0;
        if (ega || egb) begin
            fav_b  = ega;
            pend_b = egb;
            if (!lg) begin
                pend_kind = 2;
            end else if (!we) begin
                pend_kind = 1;
                v = 32'h0;
                for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[int'(ad) + k];
                if (!f[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                pend_val = v;
            end else begin
                for (int k = 0; k < sz; k++) ref_mem[int'(ad) + k] = wd[8*k +: 8];
            end
        end

        @(posedge clk);
        if (cap_en) begin
            ram_rdata = ram[cap_addr];
            for (int k = 0; k < 4; k++)
                if (cap_we[k]) ram[cap_addr][8*k +: 8] = cap_wd[8*k +: 8];
        end
        #1;
    endtask

    task automatic rand_req(output logic req, output logic we, output logic [BYTE_AW-1:0] addr,
                            output logic [31:0] wdata, output logic [2:0] f3);
        logic [2:0] opts [0:9];
        opts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b000, 3'b011, 3'b110, 3'b111};
        req   = ($urandom_range(0, 3) != 0);
        we    = $urandom_range(0, 1) == 1;
        f3    = opts[$urandom_range(0, 9)];
        addr  = BYTE_AW'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
        wdata = $urandom;
    endtask

    task automatic idle();
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;
        clk_en = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_wdata = 32'h0; a_f3 = 3'b010;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h020; b_wdata = 32'h0; b_f3 = 3'b010;
        ram_rdata = 32'h0;
        for (int i = 0; i < (1 << RAM_AW); i++) set_word(i, $urandom);
        fav_b = 1'b0; pend_kind = 0; pend_b = 1'b0; pend_val = 32'h0;

        #12;
        chk_all_zero("reset");

        // Both requesting from the first cycle after release: A, B, A, B.
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            seq[3-i] = obs_ga;
            chk("rr_one_per_cycle", {31'h0, obs_ram_en}, 32'h1);
        end
        chk("rr_sequence", {28'h0, seq}, 32'h0000000a);
        idle();
        do_cycle();

        // Word load.
        set_word(4, 32'hDEADBEEF);
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_f3 = 3'b010;
        do_cycle();
        chk("lw_addr", 32'(obs_ram_addr), 32'h4);
        idle();
        do_cycle();
        chk("lw_data", obs_a_rdata, 32'hDEADBEEF);

        // Byte/half loads with sign and zero extension, back to back.
        set_word(0, 32'h80FF_FFFF);
        a_req = 1'b1; a_addr = 12'h003; a_f3 = 3'b000;
        do_cycle();
        a_f3 = 3'b100;
        do_cycle();
        chk("lb_data", obs_a_rdata, 32'hFFFFFF80);
        set_word(0, 32'h7FFF_0000);
        a_addr = 12'h002; a_f3 = 3'b001;
        do_cycle();
        chk("lbu_data", obs_a_rdata, 32'h00000080);
        idle();
        do_cycle();
        chk("lh_data", obs_a_rdata, 32'h00007FFF);

        // Halfword store from B.
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h006; b_wdata = 32'h0000ABCD; b_f3 = 3'b001;
        do_cycle();
        chk("sh_we", {28'h0, obs_ram_we}, 32'hC);
        chk("sh_wdata", obs_ram_wdata, 32'hABCDABCD);
        chk("sh_addr", 32'(obs_ram_addr), 32'h1);
        idle();
        do_cycle();
        chk("sh_no_rvalid", {31'h0, obs_b_rvalid}, 32'h0);

        // Misaligned word load: error pulse for exactly one cycle.
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h002; a_f3 = 3'b010;
        do_cycle();
        chk("mis_gnt", {30'h0, obs_ga, obs_ram_en}, 32'h2);
        idle();
        do_cycle();
        chk("mis_err", {31'h0, obs_a_err}, 32'h1);
        do_cycle();
        chk("mis_err_end", {31'h0, obs_a_err}, 32'h0);

        // Clock enable low holds off grants.
        clk_en = 1'b0;
        a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; b_f3 = 3'b010; b_addr = 12'h020; a_addr = 12'h010;
        do_cycle();
        chk("cke_hold", {29'h0, obs_ga, obs_gb, obs_busy}, 32'h1);
        clk_en = 1'b1;
        idle();
        do_cycle();

        // Random traffic with hold-until-grant requesters.
        for (int n = 0; n < 3000; n++) begin
            if (!a_req || m_ga) rand_req(a_req, a_we, a_addr, a_wdata, a_f3);
            if (!b_req || m_gb) rand_req(b_req, b_we, b_addr, b_wdata, b_f3);
            clk_en = ($urandom_range(0, 7) != 0);
            do_cycle();
        end
        clk_en = 1'b1;
        idle();
        do_cycle();

        // Reset arriving while a load response is owed drops it.
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_f3 = 3'b010;
        do_cycle();
        chk("pre_reset_gnt", {31'h0, obs_ga}, 32'h1);
        rst_n = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 12'h020; b_f3 = 3'b010;
        fav_b = 1'b0;
        pend_kind = 0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_cycle();
        chk("post_reset_a_first", {30'h0, obs_ga, obs_a_rvalid}, 32'h2);
        idle();
        do_cycle();
        do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 10, meaning word-address width of the shared data RAM.
REQ-002 The block SHALL have parameter BYTE_AW, default RAM_AW+2, meaning byte-address width of requester ports.
REQ-003 Port i_clk, input, 1, the system clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 Port i_clk_en, input, 1, when low no new grant SHALL be issued.
REQ-006 Ports i_a_req/i_b_req, input, 1, access request from requester A (core MEM stage) and requester B (loader/debug).
REQ-007 Ports i_a_we/i_b_we, input, 1, 1=store, 0=load.
REQ-008 Ports i_a_addr/i_b_addr, input, BYTE_AW, byte address.
REQ-009 Ports i_a_wdata/i_b_wdata, input, 32, store data (right-aligned).
REQ-010 Ports i_a_funct3/i_b_funct3, input, 3, RV32I size/sign code (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-011 Ports o_a_gnt/o_b_gnt, output, 1, request accepted this cycle.
REQ-012 Ports o_a_rvalid/o_b_rvalid, output, 1, load data valid.
REQ-013 Ports o_a_rdata/o_b_rdata, output, 32, extended load data.
REQ-014 Ports o_a_err/o_b_err, output, 1, misaligned/illegal access pulse.
REQ-015 Port o_ram_en, output, 1; o_ram_we, output, 4, byte write enables; o_ram_addr, output, RAM_AW; o_ram_wdata, output, 32.
REQ-016 Port i_ram_rdata, input, 32, RAM read data, valid one cycle after o_ram_en with o_ram_we=0.
REQ-017 Port o_busy, output, 1, any request present or response outstanding.

Function
REQ-018 Requesters SHALL hold req, we, addr, wdata, funct3 stable until gnt; gnt is combinational from current inputs and arbitration state.
REQ-019 At most one of o_a_gnt/o_b_gnt SHALL be high per cycle; no gnt while i_clk_en=0.
REQ-020 Single requester: that requester SHALL be granted the same cycle.
REQ-021 Both requesting: grant SHALL go to the requester not granted most recently (round-robin pointer, updated on every gnt, reset value favours A).
REQ-022 Legality: funct3 001/101 needs addr[0]=0; 010 needs addr[1:0]=0; 011, 110, 111 illegal; store with funct3[2]=1 illegal.
REQ-023 Illegal/misaligned grant: o_ram_en=0 that cycle; o_x_err=1 for exactly the next cycle; no rvalid.
REQ-024 Legal grant: o_ram_en=1, o_ram_addr=addr[BYTE_AW-1:2] in the grant cycle.
REQ-025 Store byte: o_ram_we=4'b0001<<addr[1:0], o_ram_wdata={4{wdata[7:0]}}.
REQ-026 Store half: o_ram_we=4'b0011<<addr[1:0], o_ram_wdata={2{wdata[15:0]}}; store word: o_ram_we=4'b1111, o_ram_wdata=wdata.
REQ-027 Load: o_ram_we=0; cycle after grant o_x_rvalid=1 for one cycle, o_x_rdata=selected byte/half (offset addr[1:0] registered at grant) sign-extended for 000/001, zero-extended for 100/101, full word for 010.
REQ-028 Stores SHALL produce no rvalid and no err.
REQ-029 Response tracker SHALL be an FSM with states NONE, RD_A, RD_B, ERR_A, ERR_B; entered from the grant cycle; returns to NONE or the next grant's state each cycle.
REQ-030 A new grant SHALL be allowed in the cycle a previous response is delivered (throughput one access per cycle).
REQ-031 An outstanding response SHALL complete the next cycle regardless of i_clk_en.
REQ-032 Outside rvalid cycles o_x_rdata SHALL be 0; when no legal grant, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata SHALL be 0.
REQ-033 o_busy SHALL equal i_a_req | i_b_req | (tracker != NONE).

Reset
REQ-034 On i_rst_n low all outputs SHALL be 0 immediately, tracker SHALL go to NONE, round-robin pointer SHALL favour A.
REQ-035 A response outstanding at reset SHALL be dropped; no rvalid/err after reset release.
REQ-036 First cycle after release with both requesting SHALL grant A.

Verification
REQ-037 A LW addr 0x010, RAM returns 0xDEADBEEF -> gnt_a cycle 0, o_ram_addr=0x004, o_a_rvalid cycle 1 with o_a_rdata=0xDEADBEEF.
REQ-038 A LB addr 0x003, RAM 0x80FF_FFFF -> o_a_rdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x002, RAM 0x7FFF_0000 -> 0x00007FFF.
REQ-039 B SH addr 0x006 wdata 0x0000ABCD -> o_ram_we=4'b1100, o_ram_wdata=0xABCDABCD, o_ram_addr=0x001, no rvalid.
REQ-040 A and B request continuously after reset -> grants A,B,A,B on consecutive cycles, one RAM access per cycle, rvalid to correct port.
REQ-041 A LW addr 0x002 -> gnt_a, o_ram_en=0, o_a_err=1 next cycle only; i_clk_en=0 with requests -> no gnt, o_busy=1.
REQ-042 Reset asserted cycle after a load grant -> no rvalid emitted; all outputs 0.
